// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware return-address stack
//
// Parameters
//   IMW       PC / instruction-memory address width (>= 2)
//   RSD       return-stack depth in entries (>= 1)
//   RESET_PC  PC value after reset or start
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         synchronous restart: PC to RESET_PC, stack flushed, flags cleared
//   stall         hold all state this cycle
//   branch_taken  absolute jump to pc_in
//   branch_rel    relative jump by sign-extended pc_in
//   call          push PC+1, jump to pc_in
//   ret           pop return address into PC
//   err_clr       clear sticky overflow/underflow
//   pc_in         target address or two's-complement offset
//   pc_out        registered fetch address
//   depth         number of valid stack entries
//   stack_empty   depth == 0
//   stack_full    depth == RSD
//   overflow      sticky: call while full
//   underflow     sticky: ret while empty

module pc_stack #(
    parameter int             IMW      = 4,
    parameter int             RSD      = 4,
    parameter logic [IMW-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic                     branch_rel,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     err_clr,
    input  logic [IMW-1:0]           pc_in,
    output logic [IMW-1:0]           pc_out,
    output logic [$clog2(RSD+1)-1:0] depth,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int             DW        = $clog2(RSD + 1);
    localparam logic [DW-1:0]  DEPTH_MAX = DW'(RSD);
    localparam logic [IMW-1:0] PC_ONE    = IMW'(1);

    // One operation is selected per edge; everything of lower priority is dropped.
    typedef enum logic [2:0] {
        OP_INC,
        OP_START,
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_JUMP,
        OP_REL
    } op_e;

    op_e            op;

    logic [IMW-1:0] pc_q;
    logic [IMW-1:0] pc_d;
    logic [IMW-1:0] pc_inc;
    logic [IMW-1:0] top_val;
    logic [DW-1:0]  depth_q;
    logic [DW-1:0]  depth_d;
    logic           ovf_q;
    logic           ovf_d;
    logic           unf_q;
    logic           unf_d;
    logic           push_en;
    logic           is_empty;
    logic           is_full;

    // Return-address storage; entry i holds the (i+1)-th pushed address.
    // Contents are not reset: depth alone says which entries are valid.
    logic [IMW-1:0] stack_mem [RSD];

    assign pc_inc   = pc_q + PC_ONE;
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);

    // Top-of-stack read as a compare-mux so no out-of-range index is ever formed.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < RSD; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_val = stack_mem[i];
            end
        end
    end

    // Priority decode of the request lines.
    always_comb begin
        op = OP_INC;
        if (start) begin
            op = OP_START;
        end else if (stall) begin
            op = OP_HOLD;
        end else if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (branch_taken) begin
            op = OP_JUMP;
        end else if (branch_rel) begin
            op = OP_REL;
        end
    end

    // Next-state computation for the selected operation.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        // Clear first so that an error raised below in the same cycle wins.
        if (op != OP_START && op != OP_HOLD && err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        case (op)
            OP_START: begin
                pc_d    = RESET_PC;
                depth_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            OP_HOLD: begin
                pc_d = pc_q;
            end
            OP_RET: begin
                if (is_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d    = top_val;
                    depth_d = depth_q - DW'(1);
                end
            end
            OP_CALL: begin
                pc_d = pc_in;
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end
            OP_JUMP: begin
                pc_d = pc_in;
            end
            OP_REL: begin
                // Same-width add is the modulo-2^IMW sum with the sign-extended offset.
                pc_d = pc_q + pc_in;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Push writes the slot just above the current top, i.e. index depth_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RSD; i++) begin
            if (push_en && depth_q == DW'(i)) begin
                stack_mem[i] <= pc_inc;
            end
        end
    end

    assign pc_out      = pc_q;
    assign depth       = depth_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - self-checking bench for pc_stack with behavioural model

module tb_pc_stack;

    localparam int IMW = 4;
    localparam int RSD = 2;
    localparam int MOD = 1 << IMW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic           branch_taken = 1'b0;
    logic           branch_rel = 1'b0;
    logic           call = 1'b0;
    logic           ret = 1'b0;
    logic           err_clr = 1'b0;
    logic [IMW-1:0] pc_in = '0;
    logic [IMW-1:0] pc_out;
    logic [1:0]     depth;
    logic           stack_empty;
    logic           stack_full;
    logic           overflow;
    logic           underflow;

    pc_stack #(
        .IMW      (IMW),
        .RSD      (RSD),
        .RESET_PC (4'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_rel   (branch_rel),
        .call         (call),
        .ret          (ret),
        .err_clr      (err_clr),
        .pc_in        (pc_in),
        .pc_out       (pc_out),
        .depth        (depth),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        int off;
        if (start) begin
            model_reset();
        end else if (!stall) begin
            if (err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ret) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc  = (m_pc + 1) % MOD;
                    m_unf = 1'b1;
                end
            end else if (call) begin
                if (m_stk.size() < RSD) m_stk.push_back((m_pc + 1) % MOD);
                else m_ovf = 1'b1;
                m_pc = int'(pc_in);
            end else if (branch_taken) begin
                m_pc = int'(pc_in);
            end else if (branch_rel) begin
                off  = (int'(pc_in) >= MOD / 2) ? int'(pc_in) - MOD : int'(pc_in);
                m_pc = (m_pc + off + MOD) % MOD;
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end
    endtask

    // One clock edge: the model consumes the same inputs the DUT samples.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic set_req(input bit s, input bit st, input bit r, input bit c,
                           input bit bt, input bit br, input bit ec, input int pi);
        start        = s;
        stall        = st;
        ret          = r;
        call         = c;
        branch_taken = bt;
        branch_rel   = br;
        err_clr      = ec;
        pc_in        = IMW'(pi);
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out", pc_out, m_pc);
            chk("depth", depth, m_stk.size());
            chk("stack_empty", stack_empty, m_stk.size() == 0);
            chk("stack_full", stack_full, m_stk.size() == RSD);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_pc", pc_out, 0);
        chk("reset_empty", stack_empty, 1);
        repeat (2) cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Mid-cycle reset takes effect immediately.
        repeat (3) cyc();
        chk("pre_reset_pc", pc_out, 3);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_pc", pc_out, 0);
        chk("async_depth", depth, 0);
        chk("async_empty", stack_empty, 1);
        cyc();
        rst_n = 1'b1;

        // Free-run wrap.
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk("wrap_pc", pc_out, k % 16);
        end

        // Branches.
        repeat (2) cyc();
        chk("at3", pc_out, 3);
        set_req(0, 0, 0, 0, 1, 0, 0, 9); cyc(); chk("abs_jump", pc_out, 9);
        idle(); cyc(); chk("after_jump", pc_out, 10);
        set_req(0, 0, 0, 0, 0, 1, 0, 14); cyc(); chk("rel_back", pc_out, 8);
        idle(); repeat (7) cyc(); chk("at15", pc_out, 15);
        set_req(0, 0, 0, 0, 0, 1, 0, 2); cyc(); chk("rel_wrap", pc_out, 1);

        // Nested call/return.
        idle(); cyc(); chk("at2", pc_out, 2);
        set_req(0, 0, 0, 1, 0, 0, 0, 8); cyc(); chk("call1_pc", pc_out, 8); chk("call1_depth", depth, 1);
        idle(); cyc();
        set_req(0, 0, 0, 1, 0, 0, 0, 12); cyc(); chk("call2_pc", pc_out, 12); chk("call2_full", stack_full, 1);
        set_req(0, 0, 0, 1, 0, 0, 0, 5); cyc(); chk("ovf_pc", pc_out, 5); chk("ovf_flag", overflow, 1);
        chk("ovf_depth", depth, 2);
        set_req(0, 0, 1, 0, 0, 0, 0, 0); cyc(); chk("ret1_pc", pc_out, 10);
        cyc(); chk("ret2_pc", pc_out, 3); chk("ret2_depth", depth, 0);
        cyc(); chk("unf_pc", pc_out, 4); chk("unf_flag", underflow, 1);
        set_req(0, 0, 0, 0, 0, 0, 1, 0); cyc(); chk("clr_ovf", overflow, 0); chk("clr_unf", underflow, 0);

        // Stall with call and err_clr held off.
        idle(); cyc(); chk("at6", pc_out, 6);
        set_req(0, 1, 0, 1, 0, 0, 1, 11);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_pc", pc_out, 6);
            chk("stall_depth", depth, 0);
        end
        idle(); cyc(); chk("post_stall", pc_out, 7);

        // Priority: ret beats call and branch.
        set_req(0, 0, 0, 0, 1, 0, 0, 2); cyc();
        set_req(0, 0, 0, 1, 0, 0, 0, 6); cyc(); chk("prio_setup_depth", depth, 1);
        idle(); cyc(); chk("at7", pc_out, 7);
        set_req(0, 0, 1, 1, 1, 0, 0, 12); cyc(); chk("prio_pc", pc_out, 3); chk("prio_depth", depth, 0);
        set_req(0, 0, 1, 0, 0, 0, 1, 0); cyc(); chk("set_wins", underflow, 1);

        // Restart overrides stall.
        set_req(0, 0, 0, 1, 0, 0, 0, 8); cyc();
        set_req(0, 0, 0, 1, 0, 0, 0, 9); cyc();
        set_req(0, 0, 0, 1, 0, 0, 0, 1); cyc(); chk("restart_setup_ovf", overflow, 1);
        set_req(1, 1, 0, 0, 0, 0, 0, 0); cyc();
        chk("restart_pc", pc_out, 0); chk("restart_depth", depth, 0); chk("restart_ovf", overflow, 0);
        idle(); cyc(); chk("restart_inc", pc_out, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("rand_async_pc", pc_out, 0);
                cyc();
                rst_n = 1'b1;
            end else begin
                set_req($urandom_range(63) == 0, $urandom_range(5) == 0,
                        $urandom_range(3) == 0, $urandom_range(3) == 0,
                        $urandom_range(7) == 0, $urandom_range(7) == 0,
                        $urandom_range(7) == 0, int'($urandom_range(MOD - 1)));
                cyc();
            end
        end

        idle();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
